gvp_sequencer: RTL

Program loader and run controller for the GVP vector engine. It accepts 512-bit vector blocks from the PS-side stream and buffers them in a small FIFO. While holding the GVP in reset, it writes each block through the GVP's setvec/vp_set port, then releases reset and watches gvp_finished. It also gates host pause, so PS software sees a load → start → run → done lifecycle instead of toggling raw GVP control lines.

---
 rtl/gvp_seq_pkg.sv | 41 ++++
 rtl/gvp_sequencer_if.sv | 25 ++
 rtl/gvp_seq_fifo.sv | 62 ++++++
 rtl/gvp_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/gvp_seq_pkg.sv
// Shared types and constants for the GVP program sequencer: FSM state codes,
// 512-bit vector block field layout and the terminator block helper.
package gvp_seq_pkg;

  localparam int unsigned GVP_BLOCK_W = 512;
  localparam int unsigned GVP_FIELD_W = 32;

  // Field offsets inside one 512-bit vector block
  localparam int unsigned GVP_ADDR_OFS    = 0;
  localparam int unsigned GVP_N_OFS       = 32;
  localparam int unsigned GVP_IIN_OFS     = 64;
  localparam int unsigned GVP_OPTIONS_OFS = 96;
  localparam int unsigned GVP_NREP_OFS    = 128;
  localparam int unsigned GVP_NEXT_OFS    = 160;
  localparam int unsigned GVP_DX_OFS      = 192;
  localparam int unsigned GVP_DY_OFS      = 224;
  localparam int unsigned GVP_DZ_OFS      = 256;
  localparam int unsigned GVP_DU_OFS      = 288;
  localparam int unsigned GVP_DECI_OFS    = 320;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t ST_IDLE  = 4'd0;
  localparam seq_state_t ST_ARM   = 4'd1;
  localparam seq_state_t ST_LOAD  = 4'd2;
  localparam seq_state_t ST_SET   = 4'd3;
  localparam seq_state_t ST_GAP   = 4'd4;
  localparam seq_state_t ST_TERM  = 4'd5;
  localparam seq_state_t ST_START = 4'd6;
  localparam seq_state_t ST_RUN   = 4'd7;
  localparam seq_state_t ST_DONE  = 4'd8;

  // n == 0 at the given address marks the end of the program
  function automatic logic [GVP_BLOCK_W-1:0] term_block(input logic [31:0] addr);
    logic [GVP_BLOCK_W-1:0] blk;
    blk = '0;
    blk[GVP_ADDR_OFS +: GVP_FIELD_W] = addr;
    return blk;
  endfunction

endpackage

// File: rtl/gvp_sequencer_if.sv
// PS-side vector stream plus GVP control lines, as seen by the sequencer (slave)
// and by whatever drives the stream and models the GVP (master).
interface gvp_sequencer_if;
  import gvp_seq_pkg::*;

  logic [GVP_BLOCK_W-1:0] s_vec_tdata;
  logic                   s_vec_tvalid;
  logic                   s_vec_tready;
  logic                   gvp_reset;
  logic                   gvp_pause;
  logic                   gvp_setvec;
  logic [GVP_BLOCK_W-1:0] gvp_vp_set;
  logic                   gvp_finished;

  modport slave (
    input  s_vec_tdata, s_vec_tvalid, gvp_finished,
    output s_vec_tready, gvp_reset, gvp_pause, gvp_setvec, gvp_vp_set
  );

  modport master (
    output s_vec_tdata, s_vec_tvalid, gvp_finished,
    input  s_vec_tready, gvp_reset, gvp_pause, gvp_setvec, gvp_vp_set
  );

endinterface

// File: rtl/gvp_seq_fifo.sv
// First-word fall-through block FIFO, depth 2^DEPTH_N2. full_next is the value
// full takes after this edge, so the owner can register tready without a bubble.
module gvp_seq_fifo
  import gvp_seq_pkg::*;
#(
  parameter int unsigned DEPTH_N2 = 2
) (
  input  logic                   a_clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [GVP_BLOCK_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [GVP_BLOCK_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full_next
);

  localparam int unsigned DEPTH = 1 << DEPTH_N2;
  localparam logic [DEPTH_N2:0] DEPTH_C = {1'b1, {DEPTH_N2{1'b0}}};

  logic [GVP_BLOCK_W-1:0] mem [DEPTH];
  logic [DEPTH_N2-1:0]    wr_ptr_q, rd_ptr_q;
  logic [DEPTH_N2:0]      count_q, count_d;
  logic                   full_q;
  logic                   do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign rd_data = mem[rd_ptr_q];

  // A push into a full FIFO is fine when the head leaves in the same cycle
  always_comb begin
    do_rd     = rd_en && !empty && !flush;
    do_wr     = wr_en && (!full_q || do_rd) && !flush;
    count_d   = flush ? '0 : count_q + {{DEPTH_N2{1'b0}}, do_wr} - {{DEPTH_N2{1'b0}}, do_rd};
    full_next = (count_d == DEPTH_C);
  end

  always_ff @(posedge a_clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_next;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge a_clk) begin
    if (do_wr) mem[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/gvp_sequencer.sv
// GVP program loader / run controller: load -> start -> run -> done lifecycle.
// Optional GVP_SEQ_AUTOTERM_EN: cmd_start appends an n==0 terminator block.
module gvp_sequencer
  import gvp_seq_pkg::*;
#(
  parameter int unsigned NUM_VECTORS_N2 = 4,
  parameter int unsigned FIFO_DEPTH_N2  = 2,
  parameter int unsigned RESET_SETTLE   = 12
) (
  input  logic                    a_clk,
  input  logic                    reset,
  gvp_sequencer_if.slave          gvp_bus,
  input  logic                    cmd_load,
  input  logic                    cmd_start,
  input  logic                    cmd_abort,
  input  logic                    host_pause,
  input  logic [31:0]             setvec_hold,
  output logic                    busy,
  output logic                    running,
  output logic                    done,
  output logic                    err,
  output logic [NUM_VECTORS_N2:0] vec_count
);

  localparam int unsigned CNT_W       = NUM_VECTORS_N2 + 1;
  localparam logic [31:0] SETTLE_LAST = 32'(RESET_SETTLE - 1);
`ifdef GVP_SEQ_AUTOTERM_EN
  localparam logic [CNT_W-1:0] VEC_LIMIT = {1'b1, {NUM_VECTORS_N2{1'b0}}};
`endif

  seq_state_t             state_q, state_d;
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            hold_last;
  logic [CNT_W-1:0]       vec_count_q, vec_count_d;
  logic                   err_q, err_d;
  logic [GVP_BLOCK_W-1:0] vp_set_q, vp_set_d;
  logic                   gvp_reset_q, gvp_pause_q, gvp_setvec_q, tready_q;
  logic                   busy_q, running_q, done_q;
`ifdef GVP_SEQ_AUTOTERM_EN
  logic                   term_q, term_d;
`endif

  logic                   fifo_flush, fifo_push, fifo_pop, fifo_empty, fifo_full_next;
  logic [GVP_BLOCK_W-1:0] fifo_rd_data;

  assign fifo_push = gvp_bus.s_vec_tvalid && tready_q;
  assign hold_last = (setvec_hold == 32'd0) ? 32'd0 : setvec_hold - 32'd1;

  gvp_seq_fifo #(
    .DEPTH_N2 (FIFO_DEPTH_N2)
  ) u_fifo (
    .a_clk     (a_clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .wr_en     (fifo_push),
    .wr_data   (gvp_bus.s_vec_tdata),
    .rd_en     (fifo_pop),
    .rd_data   (fifo_rd_data),
    .empty     (fifo_empty),
    .full_next (fifo_full_next)
  );

  // cnt_q restarts at 0 on every state change; timed states leave after cnt_q reaches *_last
  always_comb begin
    state_d     = state_q;
    cnt_d       = 32'd0;
    vec_count_d = vec_count_q;
    err_d       = err_q;
    vp_set_d    = vp_set_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
`ifdef GVP_SEQ_AUTOTERM_EN
    term_d      = term_q;
`endif
    if (cmd_abort) begin
      state_d    = ST_IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cmd_load) begin
            state_d     = ST_ARM;
            vec_count_d = '0;
            err_d       = 1'b0;
            fifo_flush  = 1'b1;
          end
        end
        ST_ARM: begin
          if (cnt_q >= SETTLE_LAST) state_d = ST_LOAD;
          else                      cnt_d   = cnt_q + 32'd1;
        end
        ST_LOAD: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            vp_set_d = fifo_rd_data;
            state_d  = ST_SET;
`ifdef GVP_SEQ_AUTOTERM_EN
            term_d   = 1'b0;
`endif
          end else if (cmd_start) begin
            if (vec_count_q == '0) begin
              err_d = 1'b1;
            end else begin
`ifdef GVP_SEQ_AUTOTERM_EN
              state_d = ST_TERM;
`else
              state_d = ST_START;
`endif
            end
          end
        end
        ST_SET: begin
          if (cnt_q >= hold_last) begin
            state_d = ST_GAP;
            if (vec_count_q != '1) vec_count_d = vec_count_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt_q >= 32'd1) begin
`ifdef GVP_SEQ_AUTOTERM_EN
            state_d = term_q ? ST_START : ST_LOAD;
`else
            state_d = ST_LOAD;
`endif
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
`ifdef GVP_SEQ_AUTOTERM_EN
        ST_TERM: begin
          if (vec_count_q >= VEC_LIMIT) begin
            err_d   = 1'b1;
            state_d = ST_LOAD;
          end else begin
            vp_set_d = term_block(32'(vec_count_q));
            term_d   = 1'b1;
            state_d  = ST_SET;
          end
        end
`endif
        ST_START: begin
          if (cnt_q >= SETTLE_LAST) state_d = ST_RUN;
          else                      cnt_d   = cnt_q + 32'd1;
        end
        ST_RUN: begin
          if (gvp_bus.gvp_finished) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state_q
  always_ff @(posedge a_clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 32'd0;
      vec_count_q  <= '0;
      err_q        <= 1'b0;
      vp_set_q     <= '0;
      gvp_reset_q  <= 1'b1;
      gvp_pause_q  <= 1'b0;
      gvp_setvec_q <= 1'b0;
      tready_q     <= 1'b0;
      busy_q       <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
`ifdef GVP_SEQ_AUTOTERM_EN
      term_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vec_count_q  <= vec_count_d;
      err_q        <= err_d;
      vp_set_q     <= vp_set_d;
      gvp_reset_q  <= !(state_d inside {ST_START, ST_RUN, ST_DONE});
      gvp_pause_q  <= (state_d == ST_RUN) && host_pause;
      gvp_setvec_q <= (state_d == ST_SET);
      tready_q     <= (state_d inside {ST_LOAD, ST_SET, ST_GAP}) && !fifo_full_next;
      busy_q       <= !(state_d inside {ST_IDLE, ST_DONE});
      running_q    <= (state_d == ST_RUN);
      done_q       <= (state_q == ST_RUN) && (state_d == ST_DONE);
`ifdef GVP_SEQ_AUTOTERM_EN
      term_q       <= term_d;
`endif
    end
  end

  assign gvp_bus.s_vec_tready = tready_q;
  assign gvp_bus.gvp_reset    = gvp_reset_q;
  assign gvp_bus.gvp_pause    = gvp_pause_q;
  assign gvp_bus.gvp_setvec   = gvp_setvec_q;
  assign gvp_bus.gvp_vp_set   = vp_set_q;
  assign busy                 = busy_q;
  assign running              = running_q;
  assign done                 = done_q;
  assign err                  = err_q;
  assign vec_count            = vec_count_q;

endmodule
